// File: rtl/i2c_slave_responder.sv
// I2C target that acknowledges one fixed address, streams written bytes out and
// fetches read bytes on request. SCL/SDA are oversampled on clk; SCL is never driven.
module i2c_slave_responder #(
  parameter int unsigned I2C_ADDR_WIDTH = 7,
  parameter int unsigned I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] I2C_SLAVE_ADDRESS = I2C_ADDR_WIDTH'(7'h22)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_oe,
  output logic                      wr_valid,
  output logic [I2C_DATA_WIDTH-1:0] wr_data,
  output logic                      rd_req,
  input  logic [I2C_DATA_WIDTH-1:0] rd_data,
  output logic                      op,
  output logic                      busy
);

  localparam int unsigned AW      = I2C_ADDR_WIDTH;
  localparam int unsigned DW      = I2C_DATA_WIDTH;
  localparam int unsigned FRAME_W = AW + 1;
  // Holds every bit of a frame except the one arriving on the current edge.
  localparam int unsigned SHIFT_W = ((DW > FRAME_W) ? DW : FRAME_W) - 1;
  localparam int unsigned CNT_W   = $clog2(SHIFT_W + 2);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t             state;
  logic               scl_s1, scl_s2, scl_d;
  logic               sda_s1, sda_s2, sda_d;
  logic [CNT_W-1:0]   bit_cnt;
  logic [SHIFT_W-1:0] shift;
  logic [DW-2:0]      tx;
  logic               ack_phase;

  logic scl_rise, scl_fall, start_det, stop_det;

  // Synchronizers plus history; preset high so reset looks like an idle bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s1 <= scl_i; scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1 <= sda_i; sda_s2 <= sda_s1; sda_d <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      tx        <= '0;
      ack_phase <= 1'b0;
      sda_oe    <= 1'b0;
      wr_valid  <= 1'b0;
      wr_data   <= '0;
      rd_req    <= 1'b0;
      op        <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      rd_req   <= 1'b0;
      // STOP wins over START; both abandon any partial byte.
      if (stop_det) begin
        state     <= IDLE;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
      end else if (start_det) begin
        state     <= ADDR;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        bit_cnt   <= '0;
        shift     <= '0;
        ack_phase <= 1'b0;
      end else begin
        case (state)
          IDLE, WAIT_STOP: sda_oe <= 1'b0;
          ADDR: begin
            if (scl_rise) begin
              shift <= {shift[SHIFT_W-2:0], sda_s2};
              if (bit_cnt == CNT_W'(AW)) begin
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
                if (shift[AW-1:0] == I2C_SLAVE_ADDRESS) begin
                  op    <= sda_s2;
                  busy  <= 1'b1;
                  state <= ADDR_ACK;
                end else begin
                  state <= WAIT_STOP;
                end
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          // First falling edge starts the ACK slot, the second one ends it.
          ADDR_ACK, WR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= '0;
                if (state == ADDR_ACK && op) begin
                  rd_req <= 1'b1;
                  state  <= RD_DATA;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= WR_DATA;
                end
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              shift <= {shift[SHIFT_W-2:0], sda_s2};
              if (bit_cnt == CNT_W'(DW - 1)) begin
                wr_data   <= {shift[DW-2:0], sda_s2};
                wr_valid  <= 1'b1;
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
                state     <= WR_ACK;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          // rd_data is captured while rd_req is high; MSB goes out at once.
          RD_DATA: begin
            if (rd_req) begin
              tx     <= rd_data[DW-2:0];
              sda_oe <= ~rd_data[DW-1];
            end else if (scl_fall) begin
              if (bit_cnt == CNT_W'(DW - 1)) begin
                sda_oe    <= 1'b0;
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
                state     <= RD_ACK;
              end else begin
                sda_oe  <= ~tx[DW-2];
                tx      <= {tx[DW-3:0], 1'b0};
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_s2) begin
                busy  <= 1'b0;
                state <= WAIT_STOP;
              end else begin
                ack_phase <= 1'b1;
              end
            end else if (scl_fall && ack_phase) begin
              ack_phase <= 1'b0;
              rd_req    <= 1'b1;
              bit_cnt   <= '0;
              state     <= RD_DATA;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
